alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 54 +++++
 rtl/global_params.sv | 18 +
 rtl/rs_prio_enc.sv | 20 ++
 rtl/alu_rs.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Types and the operand-forwarding helper shared by the ALU reservation station.
`ifndef GLOBAL_PARAMS_SV
`include "global_params.sv"
`endif

package alu_rs_pkg;

  localparam int XLEN  = `XLEN;
  localparam int OP_W  = `ALU_OP_WIDTH;
  localparam int ROB_W = `ROB_SIZE_WIDTH;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
    logic             dep1;
    logic             dep2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] id;
  } rs_entry_t;

  typedef struct packed {
    logic            dep;
    logic [XLEN-1:0] val;
  } operand_t;

  // ALU broadcast wins if both buses ever carry the same tag.
  function automatic operand_t resolve(
    input logic             dep,
    input logic [ROB_W-1:0] q,
    input logic [XLEN-1:0]  val,
    input logic             alu_ready,
    input logic [ROB_W-1:0] alu_id,
    input logic [XLEN-1:0]  alu_res,
    input logic             lsb_ready,
    input logic [ROB_W-1:0] lsb_id,
    input logic [XLEN-1:0]  lsb_res
  );
    operand_t r;
    r.dep = dep;
    r.val = val;
    if (dep && alu_ready && (q == alu_id)) begin
      r.dep = 1'b0;
      r.val = alu_res;
    end else if (dep && lsb_ready && (q == lsb_id)) begin
      r.dep = 1'b0;
      r.val = lsb_res;
    end
    return r;
  endfunction

endpackage

// File: rtl/global_params.sv
// Global widths, opcodes and sizing shared by the execution-unit blocks.
`ifndef GLOBAL_PARAMS_SV
`define GLOBAL_PARAMS_SV
`define XLEN 32
`define ALU_OP_WIDTH 4
`define ROB_SIZE_WIDTH 4
`define ALU_RS_SIZE 8
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`endif

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder used for free-slot and issue selection.
module rs_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int W = $clog2(N);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are
// available, snoops ALU/LSB result buses, and issues one ready op per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = `ALU_RS_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [OP_W-1:0]  dec_op,
  input  logic [XLEN-1:0]  dec_val1,
  input  logic [XLEN-1:0]  dec_val2,
  input  logic             dec_dep1,
  input  logic             dec_dep2,
  input  logic [ROB_W-1:0] dec_q1,
  input  logic [ROB_W-1:0] dec_q2,
  input  logic [ROB_W-1:0] dec_id,
  input  logic             alu_ready,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [ROB_W-1:0] alu_id,
  input  logic             lsb_ready,
  input  logic [XLEN-1:0]  lsb_res,
  input  logic [ROB_W-1:0] lsb_id,
  output logic             rs_full,
  output logic             rs_ready,
  output logic [OP_W-1:0]  rs_op,
  output logic [XLEN-1:0]  rs_val1,
  output logic [XLEN-1:0]  rs_val2,
  output logic [ROB_W-1:0] rs_id
);

  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry_t [RS_SIZE-1:0] entries;
  operand_t  [RS_SIZE-1:0] wake1;
  operand_t  [RS_SIZE-1:0] wake2;
  operand_t                disp1;
  operand_t                disp2;
  logic      [RS_SIZE-1:0] busy_vec;
  logic      [RS_SIZE-1:0] issuable_vec;
  logic      [IDX_W-1:0]   free_idx;
  logic      [IDX_W-1:0]   issue_idx;
  logic                    free_valid;
  logic                    issue_valid;

  // Per-entry status and the post-broadcast operand view for every slot.
  always_comb begin
    busy_vec     = '0;
    issuable_vec = '0;
    wake1        = '0;
    wake2        = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]     = entries[i].busy;
      issuable_vec[i] = entries[i].busy && !entries[i].dep1 && !entries[i].dep2;
      wake1[i] = resolve(entries[i].dep1, entries[i].q1, entries[i].val1,
                         alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
      wake2[i] = resolve(entries[i].dep2, entries[i].q2, entries[i].val2,
                         alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
    end
  end

  always_comb begin
    disp1 = resolve(dec_dep1, dec_q1, dec_val1,
                    alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
    disp2 = resolve(dec_dep2, dec_q2, dec_val2,
                    alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
  end

  assign rs_full = &busy_vec;

  rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
    .req   (~busy_vec),
    .idx   (free_idx),
    .valid (free_valid)
  );

  rs_prio_enc #(.N(RS_SIZE)) u_issue_enc (
    .req   (issuable_vec),
    .idx   (issue_idx),
    .valid (issue_valid)
  );

  // Issue selection uses pre-edge state, so a slot freed here is reusable only next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries  <= '0;
      rs_ready <= 1'b0;
      rs_op    <= '0;
      rs_val1  <= '0;
      rs_val2  <= '0;
      rs_id    <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) entries[i].busy <= 1'b0;
        rs_ready <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (entries[i].busy) begin
            entries[i].dep1 <= wake1[i].dep;
            entries[i].val1 <= wake1[i].val;
            entries[i].dep2 <= wake2[i].dep;
            entries[i].val2 <= wake2[i].val;
          end
        end
        if (issue_valid) begin
          rs_ready                <= 1'b1;
          rs_op                   <= entries[issue_idx].op;
          rs_val1                 <= entries[issue_idx].val1;
          rs_val2                 <= entries[issue_idx].val2;
          rs_id                   <= entries[issue_idx].id;
          entries[issue_idx].busy <= 1'b0;
        end else begin
          rs_ready <= 1'b0;
        end
        if (dec_valid && free_valid) begin
          entries[free_idx] <= '{busy: 1'b1, op: dec_op,
                                 val1: disp1.val, val2: disp2.val,
                                 dep1: disp1.dep, dep2: disp2.dep,
                                 q1: dec_q1, q2: dec_q2, id: dec_id};
        end
      end
    end
  end

endmodule
